// File: rtl/aes_iter_core.sv
// Iterative AES-128 encrypt/decrypt engine sharing one round datapath.
// Round keys are expanded once and cached; a repeated key skips expansion.
// COLS_PER_CYCLE (1, 2 or 4) sets how many columns MixColumns handles per cycle.
module aes_iter_core #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic         AES_MODE,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_IN,
  output logic         AES_BUSY,
  output logic         AES_DONE,
  output logic [127:0] AES_MSG_OUT
);

  localparam int         M      = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] C_LAST = 2'(M - 1);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, SUB, SHIFT, MIX, ARK, DONE} state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, polynomial 0x11b
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] y;
    y = a;
    for (int i = 0; i < 6; i++) y = gf_mul(gf_mul(y, y), a);
    return gf_mul(y, y);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  // S-boxes computed from the field inverse and the affine map.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // ---------------------------------------------------------------------------
  // Round transforms; byte n of the state is s[127-8n -: 8], row n%4, column n/4
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv ? sbox_inv(s[127-8*n -: 8]) : sbox_fwd(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  // One column of MixColumns / InvMixColumns: b_i = sum_j coef[(j-i) mod 4] * a_j.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  cf [4];
    logic [7:0]  b;
    logic [31:0] o;
    cf[0] = inv ? 8'h0e : 8'h02;
    cf[1] = inv ? 8'h0b : 8'h03;
    cf[2] = inv ? 8'h0d : 8'h01;
    cf[3] = inv ? 8'h09 : 8'h01;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) b = b ^ gf_mul(cf[(j - i + 4) % 4], col[31-8*j -: 8]);
      o[31-8*i -: 8] = b;
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    rot = {prev[23:0], prev[31:24]};
    t   = {sbox_fwd(rot[31:24]), sbox_fwd(rot[23:16]),
           sbox_fwd(rot[15:8]),  sbox_fwd(rot[7:0])} ^ {rc, 24'h000000};
    n0  = prev[127:96] ^ t;
    n1  = prev[95:64]  ^ n0;
    n2  = prev[63:32]  ^ n1;
    n3  = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t       state;
  logic [3:0]   r_cnt;
  logic [1:0]   c_cnt;
  logic [127:0] st;
  logic [127:0] msg_q;
  logic         mode_q;
  logic [127:0] cached_key;
  logic         key_valid;
  logic [127:0] rk [11];

  logic         key_hit;
  logic [3:0]   rk_idx;
  logic [127:0] rk_rd;
  logic         key_we;
  logic [3:0]   key_widx;
  logic [127:0] key_wdata;
  logic [127:0] mix_state;

  assign key_hit = key_valid && (AES_KEY == cached_key);
  assign rk_rd   = rk[rk_idx];

  // Select which round key the current state reads.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rk_idx = r_cnt;
    case (state)
      KEYEXP:  rk_idx = r_cnt - 4'd1;
      INIT:    rk_idx = mode_q ? 4'd10 : 4'd0;
      ARK:     rk_idx = mode_q ? (4'd10 - r_cnt) : r_cnt;
      default: rk_idx = r_cnt;
    endcase
  end

  // Round-key store write port: key 0 at acceptance on a miss, key r during KEYEXP.
  always_comb begin
    key_we    = 1'b0;
    key_widx  = 4'd0;
    key_wdata = AES_KEY;
    if (state == IDLE && AES_START && !key_hit) begin
      key_we = 1'b1;
    end else if (state == KEYEXP) begin
      key_we    = 1'b1;
      key_widx  = r_cnt;
      key_wdata = next_round_key(rk_rd, rcon(r_cnt));
    end
  end

  // Transform the columns owned by this MIX cycle; the rest hold.
  always_comb begin
    mix_state = st;
    for (int col = 0; col < 4; col++)
      if (col / COLS_PER_CYCLE == int'(c_cnt))
        mix_state[127-32*col -: 32] = mix_col(st[127-32*col -: 32], mode_q);
  end

  // Round-key store.
  // NOTE: the key store is a plain memory with no reset; key_valid alone says whether it is usable.
  always_ff @(posedge CLK) begin
    if (key_we) rk[key_widx] <= key_wdata;
  end

  // Control FSM, round datapath and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (!RESET) begin
      state       <= IDLE;
      r_cnt       <= '0;
      c_cnt       <= '0;
      st          <= '0;
      msg_q       <= '0;
      mode_q      <= 1'b0;
      cached_key  <= '0;
      key_valid   <= 1'b0;
      AES_BUSY    <= 1'b0;
      AES_DONE    <= 1'b0;
      AES_MSG_OUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (AES_START) begin
            mode_q   <= AES_MODE;
            msg_q    <= AES_MSG_IN;
            AES_BUSY <= 1'b1;
            r_cnt    <= 4'd1;
            c_cnt    <= '0;
            if (key_hit) begin
              state <= INIT;
            end else begin
              cached_key <= AES_KEY;
              key_valid  <= 1'b0;
              state      <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          if (r_cnt == 4'd10) begin
            key_valid <= 1'b1;
            r_cnt     <= 4'd1;
            state     <= INIT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        INIT: begin
          st    <= msg_q ^ rk_rd;
          r_cnt <= 4'd1;
          state <= mode_q ? SHIFT : SUB;
        end
        SUB: begin
          st    <= sub_bytes(st, mode_q);
          state <= mode_q ? ARK : SHIFT;
        end
        SHIFT: begin
          st <= shift_rows(st, mode_q);
          if (mode_q)              state <= SUB;
          else if (r_cnt == 4'd10) state <= ARK;
          else                     state <= MIX;
        end
        MIX: begin
          st <= mix_state;
          if (c_cnt == C_LAST) begin
            c_cnt <= '0;
            if (mode_q) begin
              r_cnt <= r_cnt + 4'd1;
              state <= SHIFT;
            end else begin
              state <= ARK;
            end
          end else begin
            c_cnt <= c_cnt + 2'd1;
          end
        end
        ARK: begin
          st <= st ^ rk_rd;
          if (r_cnt == 4'd10) begin
            AES_MSG_OUT <= st ^ rk_rd;
            AES_BUSY    <= 1'b0;
            AES_DONE    <= 1'b1;
            state       <= DONE;
          end else if (mode_q) begin
            state <= MIX;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            state <= SUB;
          end
        end
        DONE: begin
          if (!AES_START) begin
            AES_DONE <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Parametrised iterative AES-128 engine performing both encryption and decryption from one shared round datapath, selected per operation. It caches the expanded key schedule so back-to-back operations under the same key skip key expansion. Column-mixing throughput is a build-time parameter. It sits between the Avalon-MM register interface, which supplies key, message, mode and START, and the software polling loop that waits on DONE.

## Interface
- COLS_PER_CYCLE, default 1: MixColumns/InvMixColumns columns processed per cycle; legal values 1, 2, 4. Define M = 4/COLS_PER_CYCLE.
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- AES_START  input  1  level request; sampled only in IDLE.
- AES_MODE  input  1  0 = encrypt, 1 = decrypt; captured at acceptance.
- AES_KEY  input  128  cipher key; captured at acceptance.
- AES_MSG_IN  input  128  plaintext (encrypt) or ciphertext (decrypt); captured at acceptance.
- AES_BUSY  output  1  high from the cycle after acceptance until DONE state is entered.
- AES_DONE  output  1  high in DONE state.
- AES_MSG_OUT  output  128  registered result; holds the last completed result until overwritten.

## Operation
- States: IDLE, KEYEXP, INIT, SUB, SHIFT, MIX, ARK, DONE.
- Acceptance: in IDLE with AES_START=1, capture MODE, KEY and MSG_IN into internal registers. Inputs may change afterward without effect.
- Key cache: 11×128 round-key store, a key_valid flag and a cached-key register. At acceptance:
  - If key_valid=1 and AES_KEY equals the cached key, go to INIT.
  - Otherwise go to KEYEXP. KEYEXP generates round key i in cycle i (i = 1..10, rcon 01,02,04,08,10,20,40,80,1b,36). It sets key_valid at exit, then goes to INIT.
- INIT: state = msg XOR k0 (encrypt) or msg XOR k10 (decrypt). Round counter r = 1.
- Encrypt round r: SUB (SubBytes) → SHIFT (ShiftRows) → MIX (r<10 only) → ARK (XOR k_r).
- Decrypt round r: SHIFT (InvShiftRows) → SUB (InvSubBytes) → ARK (XOR k_(10−r)) → MIX (InvMixColumns, r<10 only).
  - Order within a round is the FSM's concern; SUB and SHIFT states use the mode-selected transform.
- Each of SUB, SHIFT and ARK is exactly 1 cycle. MIX is M cycles:
  - Column counter c starts at 0.
  - Columns c·COLS_PER_CYCLE … +COLS_PER_CYCLE−1 are transformed and written back in place; other columns hold.
  - Column 0 = state[127:96].
- After the last step of round 10, load AES_MSG_OUT and enter DONE. r increments at the end of each round.
- DONE: AES_DONE=1. Return to IDLE when AES_START=0. While START remains 1, stay in DONE; there is no retrigger.
- AES_START is ignored in every state other than IDLE and DONE.
- Reset (any state, asynchronous): state → IDLE; AES_BUSY=0; AES_DONE=0; AES_MSG_OUT=0; key_valid=0; counters 0. An aborted operation produces no output.
- All byte arithmetic is GF(2^8) with polynomial 0x11b. Counters r (4 bits) and c (2 bits) never wrap mid-operation.

## Timing
- Acceptance edge = edge 0. DONE state is entered, and AES_MSG_OUT is valid, at edge L:
  - L = 31 + 9M with a cached key.
  - L = 41 + 9M with key expansion.
- Resulting values:
  - COLS_PER_CYCLE=1 (M=4): L = 67 cached, 77 expanding.
  - COLS_PER_CYCLE=4 (M=1): L = 40 cached, 50 expanding.
- AES_BUSY rises at edge 0 and falls at edge L.
- AES_DONE rises at edge L and falls on the first edge where START=0 is sampled in DONE.
- Earliest next acceptance is one cycle after DONE exits (IDLE must be visited).

## Test plan
- FIPS-197 C.1 encrypt, COLS_PER_CYCLE=1: key 000102030405060708090a0b0c0d0e0f, msg 00112233445566778899aabbccddeeff, mode 0 → AES_MSG_OUT 69c4e0d86a7b0430d8cdb78070b4c55a. DONE at edge 77 after acceptance.
- Decrypt, same key, immediately after the previous test: msg 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 → 00112233445566778899aabbccddeeff. DONE at edge 67 (cached key). Repeat with a changed key and confirm edge 77.
- Latency sweep: rebuild with COLS_PER_CYCLE=2 and 4, repeat both vectors → identical results. Cached-key DONE at edges 49 and 40 respectively.
- Handshake: hold START high 200 cycles → exactly one operation; DONE stays high; BUSY low after completion. Drop START → DONE falls the next edge. Change MSG_IN mid-operation → result unchanged.
- Reset mid-operation: assert RESET low at edge 30 of an operation → AES_MSG_OUT=0, DONE=0, BUSY=0 immediately. The next START with the same key takes the expansion path (DONE at edge 77) and returns the correct vector.
